// File: rtl/led_pattern_engine.sv
// LED pattern engine: shadows the LED_Ctrl register bank and steps static/blink/rotate/ping-pong/count
// patterns onto the LED pins. Define LED_PWM_EN to gate the LEDs with a brightness PWM.
module led_pattern_engine #(
    parameter int NUM_LEDS = 8,
    parameter int PWM_W    = 8
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [31:0]         cfg_ctrl,
    input  logic [31:0]         cfg_period,
    input  logic [31:0]         cfg_pattern,
    input  logic [31:0]         cfg_bright,
    input  logic                cfg_wr_strobe,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_tick,
    output logic [15:0]         step_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [2:0] M_BLINK = 3'd1;
    localparam logic [2:0] M_ROTL  = 3'd2;
    localparam logic [2:0] M_ROTR  = 3'd3;
    localparam logic [2:0] M_PING  = 3'd4;
    localparam logic [2:0] M_COUNT = 3'd5;
    localparam logic [NUM_LEDS-1:0] ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  sh_en_q;
    logic [2:0]            sh_mode_q;
    logic [31:0]           sh_period_q;
    logic [NUM_LEDS-1:0]   sh_pattern_q;
    logic                  pending_q, pending_d;
    logic [31:0]           presc_q, presc_d, presc_max;
    logic                  tick_q, tick_d;
    logic [15:0]           count_q, count_d;
    logic [NUM_LEDS-1:0]   pat_q, pat_d, pat_step;
    logic [NUM_LEDS-1:0]   last_q, pat_out;
    logic [NUM_LEDS-1:0]   led_q, led_d;
    logic                  dir_q, dir_d, dir_step;
    logic                  phase_q, phase_d;
    logic                  load;
    logic                  unused_cfg;

    assign unused_cfg = ^{cfg_ctrl[31:4], cfg_pattern, cfg_bright, sh_en_q};

    assign presc_max = (sh_period_q == 32'd0) ? 32'd0 : sh_period_q - 32'd1;

    // IDLE picks up a write the cycle after the strobe; RUN defers it to a step boundary.
    always_comb begin
        load = 1'b0;
        if (state_q == IDLE)
            load = pending_q;
        else if (state_q == RUN)
            load = tick_q && (pending_q || cfg_wr_strobe);
    end

    assign pending_d = (pending_q && !load) || (cfg_wr_strobe && !(load && state_q == RUN));

    // dir_q: 0 = moving toward MSB, 1 = moving toward LSB
    always_comb begin
        pat_step = pat_q;
        dir_step = dir_q;
        case (sh_mode_q)
            M_ROTL:  pat_step = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
            M_ROTR:  pat_step = {pat_q[0], pat_q[NUM_LEDS-1:1]};
            M_PING: begin
                if (!dir_q) begin
                    if (pat_q[NUM_LEDS-1]) begin
                        pat_step = pat_q >> 1;
                        dir_step = 1'b1;
                    end else begin
                        pat_step = pat_q << 1;
                    end
                end else begin
                    if (pat_q[0]) begin
                        pat_step = pat_q << 1;
                        dir_step = 1'b0;
                    end else begin
                        pat_step = pat_q >> 1;
                    end
                end
            end
            M_COUNT: pat_step = pat_q + ONE;
            default: pat_step = pat_q;
        endcase
    end

    // LOAD keeps showing the last displayed pattern so a reload never blanks the LEDs.
    always_comb begin
        case (state_q)
            RUN:     pat_out = (sh_mode_q == M_BLINK && phase_q) ? '0 : pat_q;
            LOAD:    pat_out = last_q;
            default: pat_out = '0;
        endcase
    end

`ifdef LED_PWM_EN
    localparam logic [PWM_W-1:0] PWM_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    logic [PWM_W-1:0] sh_bright_q;
    logic [PWM_W-1:0] pwm_cnt_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            pwm_cnt_q   <= '0;
            sh_bright_q <= '0;
        end else begin
            pwm_cnt_q <= (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + {{(PWM_W-1){1'b0}}, 1'b1};
            if (load)
                sh_bright_q <= cfg_bright[PWM_W-1:0];
        end
    end

    assign led_d = pat_out & {NUM_LEDS{pwm_cnt_q < sh_bright_q}};
`else
    assign led_d = pat_out;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        pat_d   = pat_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                presc_d = '0;
                pat_d   = '0;
                dir_d   = 1'b0;
                phase_d = 1'b0;
                if (load && cfg_ctrl[0])
                    state_d = LOAD;
            end
            LOAD: begin
                pat_d   = (sh_mode_q == M_PING) ? ONE : sh_pattern_q;
                dir_d   = 1'b0;
                phase_d = 1'b0;
                presc_d = '0;
                count_d = '0;
                state_d = RUN;
            end
            RUN: begin
                if (load) begin
                    state_d = cfg_ctrl[0] ? LOAD : IDLE;
                    presc_d = '0;
                end else if (tick_q) begin
                    presc_d = '0;
                    count_d = count_q + 16'd1;
                    pat_d   = pat_step;
                    dir_d   = dir_step;
                    phase_d = ~phase_q;
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tick is registered: it is high in exactly the cycle the prescaler sits at its last count.
    assign tick_d = (state_d == RUN) && (presc_d == presc_max);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            sh_en_q      <= 1'b0;
            sh_mode_q    <= '0;
            sh_period_q  <= '0;
            sh_pattern_q <= '0;
            pending_q    <= 1'b0;
            presc_q      <= '0;
            tick_q       <= 1'b0;
            count_q      <= '0;
            pat_q        <= '0;
            last_q       <= '0;
            led_q        <= '0;
            dir_q        <= 1'b0;
            phase_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            count_q   <= count_d;
            pat_q     <= pat_d;
            last_q    <= pat_out;
            led_q     <= led_d;
            dir_q     <= dir_d;
            phase_q   <= phase_d;
            if (load) begin
                sh_en_q      <= cfg_ctrl[0];
                sh_mode_q    <= cfg_ctrl[3:1];
                sh_period_q  <= cfg_period;
                sh_pattern_q <= cfg_pattern[NUM_LEDS-1:0];
            end
        end
    end

    assign led        = led_q;
    assign step_tick  = tick_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine: stimulus pushes expected {step_count, led, gap} per step_tick,
// a negedge monitor pops and compares whenever the engine ticks.
module tb_led_pattern_engine;
    localparam int N = 8;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic [31:0]   cfg_ctrl = '0;
    logic [31:0]   cfg_period = '0;
    logic [31:0]   cfg_pattern = '0;
    logic [31:0]   cfg_bright = 32'hFF;
    logic          cfg_wr_strobe = 1'b0;
    logic [N-1:0]  led;
    logic          step_tick;
    logic [15:0]   step_count;

    typedef struct packed {
        logic [15:0] cnt;
        logic [7:0]  led;
        logic [7:0]  gap;   // cycles since previous tick, 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_tick = 0;
    int   tick_seen = 0;
    bit   mon_en = 1'b0;

    led_pattern_engine #(.NUM_LEDS(N), .PWM_W(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cfg_ctrl(cfg_ctrl), .cfg_period(cfg_period), .cfg_pattern(cfg_pattern),
        .cfg_bright(cfg_bright), .cfg_wr_strobe(cfg_wr_strobe),
        .led(led), .step_tick(step_tick), .step_count(step_count)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    always @(negedge ACLK) begin
        if (step_tick) begin
            tick_seen++;
            if (mon_en) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_tick got cnt=%0d led=%h, none expected", step_count, led);
                end else begin
                    me = exp_q.pop_front();
                    if (step_count !== me.cnt || led !== me.led ||
                        (me.gap != 0 && (cyc - last_tick) != int'(me.gap))) begin
                        bad++;
                        $display("FAIL tick got cnt=%0d led=%h gap=%0d, want cnt=%0d led=%h gap=%0d",
                                 step_count, led, cyc - last_tick, me.cnt, me.led, me.gap);
                    end
                end
            end
            last_tick = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic push(input int cnt, input logic [7:0] l, input int gap);
        exp_t e;
        e.cnt = 16'(cnt);
        e.led = l;
        e.gap = 8'(gap);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge ACLK); #1 ARESET = 1'b1;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b0;
    endtask

    task automatic write_cfg(input logic [31:0] c, input logic [31:0] p,
                             input logic [31:0] pat, input logic [31:0] b);
        @(posedge ACLK);
        #1;
        cfg_ctrl = c; cfg_period = p; cfg_pattern = pat; cfg_bright = b;
        cfg_wr_strobe = 1'b1;
        @(posedge ACLK);
        #1 cfg_wr_strobe = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge ACLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got %0d ticks outstanding, want 0", name, exp_q.size());
            exp_q.delete();
        end
        mon_en = 1'b0;
    endtask

    task automatic wait_ticks(input int n, input int budget);
        int seen = 0;
        int c = 0;
        while (seen < n && c < budget) begin
            @(negedge ACLK);
            c++;
            if (step_tick) seen++;
        end
        if (seen < n) begin
            total++;
            bad++;
            $display("FAIL wait_ticks got %0d ticks, want %0d", seen, n);
        end
    endtask

    initial begin
        int t0;
        int on_cnt;
        logic [7:0] rot_exp [0:8];
        logic [7:0] ping_exp [0:15];
        rot_exp  = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        ping_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                     8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("reset_led", 32'(led), 32'h0);
        check("reset_tick", 32'(step_tick), 32'h0);
        check("reset_count", 32'(step_count), 32'h0);

        // static 0xA5, period 4
        mon_en = 1'b1;
        push(0, 8'hA5, 0); push(1, 8'hA5, 4); push(2, 8'hA5, 4);
        write_cfg(32'h1, 32'd4, 32'hA5, 32'hFF);
        drain("static", 100);

        // rotate-left 0x81, period 1: first tick still shows the idle blank
        do_reset();
        mon_en = 1'b1;
        push(0, 8'h00, 0);
        for (int k = 0; k < 9; k++) push(k + 1, rot_exp[k], 1);
        write_cfg(32'h5, 32'd1, 32'h81, 32'hFF);
        drain("rotate", 100);

        // ping-pong, period 1: no repeated endpoint
        do_reset();
        mon_en = 1'b1;
        push(0, 8'h00, 0);
        for (int k = 0; k < 16; k++) push(k + 1, ping_exp[k], 1);
        write_cfg(32'h9, 32'd1, 32'h55, 32'hFF);
        drain("pingpong", 100);

        // blink 0x3C, period 10; rewrite pattern at prescaler=3, loads on the next tick
        do_reset();
        mon_en = 1'b1;
        push(0, 8'h3C, 0); push(1, 8'h00, 10); push(2, 8'h3C, 10);
        push(3, 8'h00, 10); push(0, 8'h0F, 11); push(1, 8'h00, 10);
        write_cfg(32'h3, 32'd10, 32'h3C, 32'hFF);
        wait_ticks(3, 100);
        repeat (3) @(posedge ACLK);
        write_cfg(32'h3, 32'd10, 32'h0F, 32'hFF);
        drain("blink_reload", 200);

        // disable mid-run: consumed tick, then IDLE with LEDs off
        do_reset();
        mon_en = 1'b1;
        push(0, 8'hFF, 0); push(1, 8'hFF, 5); push(2, 8'hFF, 5);
        write_cfg(32'h1, 32'd5, 32'hFF, 32'hFF);
        wait_ticks(2, 100);
        write_cfg(32'h0, 32'd5, 32'hFF, 32'hFF);
        drain("disable", 100);
        t0 = tick_seen;
        repeat (10) @(negedge ACLK);
        check("idle_led", 32'(led), 32'h0);
        check("idle_count", 32'(step_count), 32'd2);
        check("idle_no_ticks", 32'(tick_seen - t0), 32'd0);

        // period 0 ticks every cycle; then a one-cycle reset mid-run
        do_reset();
        mon_en = 1'b1;
        push(0, 8'h00, 0); push(1, 8'hFF, 1); push(2, 8'hFF, 1); push(3, 8'hFF, 1);
        write_cfg(32'h1, 32'd0, 32'hFF, 32'hFF);
        drain("period0", 100);
        @(posedge ACLK); #1 ARESET = 1'b1;
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("midreset_led", 32'(led), 32'h0);
        check("midreset_tick", 32'(step_tick), 32'h0);
        check("midreset_count", 32'(step_count), 32'h0);
        t0 = tick_seen;
        repeat (5) @(negedge ACLK);
        check("postreset_no_ticks", 32'(tick_seen - t0), 32'd0);

`ifdef LED_PWM_EN
        // brightness 64 of 255, then 0
        do_reset();
        write_cfg(32'h1, 32'd2, 32'hFF, 32'd64);
        repeat (20) @(negedge ACLK);
        on_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge ACLK);
            if (led == 8'hFF) on_cnt++;
        end
        check("pwm64_on_cycles", 32'(on_cnt), 32'd64);
        write_cfg(32'h1, 32'd2, 32'hFF, 32'd0);
        repeat (10) @(negedge ACLK);
        on_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge ACLK);
            if (led != 8'h00) on_cnt++;
        end
        check("pwm0_on_cycles", 32'(on_cnt), 32'd0);
`else
        // brightness input has no effect without PWM
        do_reset();
        mon_en = 1'b1;
        push(0, 8'h5A, 0); push(1, 8'h5A, 3);
        write_cfg(32'h1, 32'd3, 32'h5A, 32'd0);
        drain("bright_ignored", 100);
        on_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (led == 8'h5A) on_cnt++;
        end
        check("bright_ignored_on_cycles", 32'(on_cnt), 32'd20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
